// File: rtl/channel_extractor_if.sv
// Pixel-in / channel-out handshake bundle for channel_extractor.
// The invert signal exists only when CHANNEL_EXTRACT_INVERT_EN is defined.
interface channel_extractor_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 3,
  parameter int SEL_W  = 2
);
  logic [NUM_CH*DATA_W-1:0] pix_in;
  logic                     in_valid;
  logic                     in_ready;
  logic [SEL_W-1:0]         channel_select;
  logic [1:0]               mode;
`ifdef CHANNEL_EXTRACT_INVERT_EN
  logic                     invert;
`endif
  logic [DATA_W-1:0]        out_data;
  logic [SEL_W-1:0]         out_ch;
  logic                     out_last;
  logic                     out_valid;
  logic                     out_ready;

`ifdef CHANNEL_EXTRACT_INVERT_EN
  modport slave (
    input  pix_in, in_valid, channel_select, mode, invert, out_ready,
    output in_ready, out_data, out_ch, out_last, out_valid
  );
  modport master (
    output pix_in, in_valid, channel_select, mode, invert, out_ready,
    input  in_ready, out_data, out_ch, out_last, out_valid
  );
`else
  modport slave (
    input  pix_in, in_valid, channel_select, mode, out_ready,
    output in_ready, out_data, out_ch, out_last, out_valid
  );
  modport master (
    output pix_in, in_valid, channel_select, mode, out_ready,
    input  in_ready, out_data, out_ch, out_last, out_valid
  );
`endif
endinterface

// File: rtl/channel_extractor.sv
// Pixel channel extractor: single channel, serialised channels, max or min per pixel.
// Optional output inversion is enabled by defining CHANNEL_EXTRACT_INVERT_EN.
module channel_extractor #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 3,
  parameter int SEL_W  = 2
) (
  input  logic           clk,
  input  logic           rst,
  channel_extractor_if.slave bus
);

  localparam int PIX_W = NUM_CH * DATA_W;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_CH - 1);

  typedef enum logic {IDLE, EMIT} state_e;

  state_e              state_q, state_d;
  logic [PIX_W-1:0]    pix_q, pix_d;
  logic                inv_q, inv_d;
  logic [SEL_W-1:0]    beat_q, beat_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [SEL_W-1:0]    out_ch_q, out_ch_d;
  logic                out_last_q, out_last_d;
  logic [DATA_W-1:0]   res_c;
  logic                inv_in;
  logic                out_valid;
  logic                accept;
  logic                consume;

  function automatic logic [DATA_W-1:0] chan(input logic [PIX_W-1:0] pix,
                                             input logic [SEL_W-1:0] idx);
    chan = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (int'(idx) == k) chan = pix[k*DATA_W +: DATA_W];
  endfunction

  // Strict compare keeps the lowest index on ties.
  function automatic logic [SEL_W+DATA_W-1:0] extreme(input logic [PIX_W-1:0] pix,
                                                      input logic want_min);
    logic [DATA_W-1:0] best;
    logic [DATA_W-1:0] c;
    logic [SEL_W-1:0]  bi;
    best = pix[DATA_W-1:0];
    bi   = '0;
    for (int k = 1; k < NUM_CH; k++) begin
      c = pix[k*DATA_W +: DATA_W];
      if (want_min ? (c < best) : (c > best)) begin
        best = c;
        bi   = SEL_W'(k);
      end
    end
    return {bi, best};
  endfunction

  function automatic logic [DATA_W-1:0] apply_inv(input logic [DATA_W-1:0] d,
                                                  input logic inv);
    return inv ? ~d : d;
  endfunction

`ifdef CHANNEL_EXTRACT_INVERT_EN
  assign inv_in = bus.invert;
`else
  assign inv_in = 1'b0;
`endif

  assign out_valid     = (state_q == EMIT);
  assign bus.in_ready  = !rst && (!out_valid || (bus.out_ready && out_last_q));
  assign accept        = bus.in_valid && bus.in_ready;
  assign consume       = out_valid && bus.out_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_last  = out_last_q;

  always_comb begin
    state_d    = state_q;
    pix_d      = pix_q;
    inv_d      = inv_q;
    beat_d     = beat_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    out_last_d = out_last_q;
    res_c      = '0;
    if (accept) begin
      state_d  = EMIT;
      pix_d    = bus.pix_in;
      inv_d    = inv_in;
      beat_d   = '0;
      out_ch_d = '0;
      case (bus.mode)
        2'b00: begin
          res_c      = chan(bus.pix_in, bus.channel_select);
          out_ch_d   = bus.channel_select;
          out_last_d = 1'b1;
        end
        2'b01: begin
          res_c      = chan(bus.pix_in, '0);
          out_last_d = 1'b0;
        end
        2'b10: begin
          {out_ch_d, res_c} = extreme(bus.pix_in, 1'b0);
          out_last_d        = 1'b1;
        end
        default: begin
          {out_ch_d, res_c} = extreme(bus.pix_in, 1'b1);
          out_last_d        = 1'b1;
        end
      endcase
      out_data_d = apply_inv(res_c, inv_in);
    end else if (consume) begin
      if (out_last_q) begin
        state_d = IDLE;
      end else begin
        // Only serialise pixels have non-last beats, so no mode register is needed.
        beat_d     = beat_q + SEL_W'(1);
        res_c      = chan(pix_q, beat_d);
        out_data_d = apply_inv(res_c, inv_q);
        out_ch_d   = beat_d;
        out_last_d = (beat_d == LAST_IDX);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      inv_q      <= 1'b0;
      beat_q     <= '0;
      out_data_q <= '0;
      out_ch_q   <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      inv_q      <= inv_d;
      beat_q     <= beat_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
      out_last_q <= out_last_d;
    end
  end

  always_ff @(posedge clk) begin
    pix_q <= pix_d;
  end

endmodule

// File: tb/tb_channel_extractor.sv
// Bench for channel_extractor: directed cases on the 8b x 3 build, random scoreboard on 10b x 4.
module tb_channel_extractor;

  localparam int B_DW = 10;
  localparam int B_NC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  always #5 clk = ~clk;

  channel_extractor_if #(.DATA_W(8),    .NUM_CH(3),    .SEL_W(2)) if_a ();
  channel_extractor_if #(.DATA_W(B_DW), .NUM_CH(B_NC), .SEL_W(2)) if_b ();

  channel_extractor #(.DATA_W(8),    .NUM_CH(3),    .SEL_W(2)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  channel_extractor #(.DATA_W(B_DW), .NUM_CH(B_NC), .SEL_W(2)) u_b (.clk(clk), .rst(rst), .bus(if_b));

  typedef struct packed {
    logic [B_DW-1:0] d;
    logic [1:0]      c;
    logic            l;
  } beat_t;

  beat_t exp_q[$];

  function automatic logic [B_DW-1:0] ref_ch(input logic [B_DW*B_NC-1:0] pix, input int k);
    logic [B_DW*B_NC-1:0] sh;
    sh = pix >> (k * B_DW);
    return sh[B_DW-1:0];
  endfunction

  function automatic void model_push(input logic [B_DW*B_NC-1:0] pix, input logic [1:0] mode,
                                     input logic [1:0] sel, input logic inv);
    beat_t b;
    int    best_i;
    if (mode == 2'b01) begin
      for (int k = 0; k < B_NC; k++) begin
        b.d = inv ? ~ref_ch(pix, k) : ref_ch(pix, k);
        b.c = 2'(k);
        b.l = (k == B_NC - 1);
        exp_q.push_back(b);
      end
    end else begin
      if (mode == 2'b00) begin
        best_i = int'(sel);
      end else begin
        best_i = 0;
        for (int k = 1; k < B_NC; k++)
          if ((mode == 2'b10) ? (ref_ch(pix, k) > ref_ch(pix, best_i))
                              : (ref_ch(pix, k) < ref_ch(pix, best_i)))
            best_i = k;
      end
      b.d = inv ? ~ref_ch(pix, best_i) : ref_ch(pix, best_i);
      b.c = 2'(best_i);
      b.l = 1'b1;
      exp_q.push_back(b);
    end
  endfunction

  task automatic test_reset();
    if_a.pix_in = '0; if_a.in_valid = 1'b0; if_a.channel_select = '0; if_a.mode = '0; if_a.out_ready = 1'b1;
    if_b.pix_in = '0; if_b.in_valid = 1'b0; if_b.channel_select = '0; if_b.mode = '0; if_b.out_ready = 1'b1;
`ifdef CHANNEL_EXTRACT_INVERT_EN
    if_a.invert = 1'b0;
    if_b.invert = 1'b0;
`endif
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if ({if_a.out_valid, if_a.out_data, if_a.out_ch, if_a.out_last} !== 12'h000)
      $display("FAIL reset_outputs got=%h exp=%h", {if_a.out_valid, if_a.out_data, if_a.out_ch, if_a.out_last}, 12'h000);
    else pass_cnt++;
    chk_cnt++;
    if (if_a.in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", if_a.in_ready);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    chk_cnt++;
    if ({if_a.in_ready, if_b.in_ready} !== 2'b11) $display("FAIL release_in_ready got=%b exp=11", {if_a.in_ready, if_b.in_ready});
    else pass_cnt++;
  endtask

  task automatic test_single();
    @(negedge clk);
    if_a.pix_in = 24'h302010; if_a.mode = 2'b00; if_a.channel_select = 2'd1;
    if_a.in_valid = 1'b1; if_a.out_ready = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if ({if_a.out_valid, if_a.out_data, if_a.out_ch, if_a.out_last} !== {1'b1, 8'h20, 2'd1, 1'b1})
      $display("FAIL single_sel1 got=%h exp=%h", {if_a.out_valid, if_a.out_data, if_a.out_ch, if_a.out_last}, {1'b1, 8'h20, 2'd1, 1'b1});
    else pass_cnt++;
    if_a.channel_select = 2'd2;
    #1;
    chk_cnt++;
    if (if_a.in_ready !== 1'b1) $display("FAIL single_b2b_ready got=%b exp=1", if_a.in_ready);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({if_a.out_valid, if_a.out_data, if_a.out_ch, if_a.out_last} !== {1'b1, 8'h30, 2'd2, 1'b1})
      $display("FAIL single_sel2 got=%h exp=%h", {if_a.out_valid, if_a.out_data, if_a.out_ch, if_a.out_last}, {1'b1, 8'h30, 2'd2, 1'b1});
    else pass_cnt++;
    if_a.in_valid = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (if_a.out_valid !== 1'b0) $display("FAIL single_idle got=%b exp=0", if_a.out_valid);
    else pass_cnt++;
  endtask

  task automatic test_serialise();
    @(negedge clk);
    if_a.pix_in = 24'hC3B2A1; if_a.mode = 2'b01; if_a.channel_select = 2'd2;
    if_a.in_valid = 1'b1; if_a.out_ready = 1'b1;
    @(negedge clk);
    if_a.in_valid = 1'b0;
    if_a.pix_in = 24'h000000;
    #1;
    chk_cnt++;
    if ({if_a.out_valid, if_a.out_data, if_a.out_ch, if_a.out_last, if_a.in_ready} !== {1'b1, 8'hA1, 2'd0, 1'b0, 1'b0})
      $display("FAIL ser_beat0 got=%h exp=%h", {if_a.out_valid, if_a.out_data, if_a.out_ch, if_a.out_last, if_a.in_ready}, {1'b1, 8'hA1, 2'd0, 1'b0, 1'b0});
    else pass_cnt++;
    @(negedge clk);
    if_a.out_ready = 1'b0;
    #1;
    chk_cnt++;
    if ({if_a.out_valid, if_a.out_data, if_a.out_ch, if_a.out_last, if_a.in_ready} !== {1'b1, 8'hB2, 2'd1, 1'b0, 1'b0})
      $display("FAIL ser_beat1 got=%h exp=%h", {if_a.out_valid, if_a.out_data, if_a.out_ch, if_a.out_last, if_a.in_ready}, {1'b1, 8'hB2, 2'd1, 1'b0, 1'b0});
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({if_a.out_valid, if_a.out_data, if_a.out_ch, if_a.out_last} !== {1'b1, 8'hB2, 2'd1, 1'b0})
      $display("FAIL ser_stall_hold got=%h exp=%h", {if_a.out_valid, if_a.out_data, if_a.out_ch, if_a.out_last}, {1'b1, 8'hB2, 2'd1, 1'b0});
    else pass_cnt++;
    if_a.out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk_cnt++;
    if ({if_a.out_valid, if_a.out_data, if_a.out_ch, if_a.out_last, if_a.in_ready} !== {1'b1, 8'hC3, 2'd2, 1'b1, 1'b1})
      $display("FAIL ser_beat2 got=%h exp=%h", {if_a.out_valid, if_a.out_data, if_a.out_ch, if_a.out_last, if_a.in_ready}, {1'b1, 8'hC3, 2'd2, 1'b1, 1'b1});
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (if_a.out_valid !== 1'b0) $display("FAIL ser_done got=%b exp=0", if_a.out_valid);
    else pass_cnt++;
  endtask

  task automatic test_maxmin();
    @(negedge clk);
    if_a.pix_in = 24'h407F7F; if_a.mode = 2'b10; if_a.in_valid = 1'b1; if_a.out_ready = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if ({if_a.out_valid, if_a.out_data, if_a.out_ch, if_a.out_last} !== {1'b1, 8'h7F, 2'd0, 1'b1})
      $display("FAIL max_tie got=%h exp=%h", {if_a.out_valid, if_a.out_data, if_a.out_ch, if_a.out_last}, {1'b1, 8'h7F, 2'd0, 1'b1});
    else pass_cnt++;
    if_a.pix_in = 24'h050905; if_a.mode = 2'b11;
    @(negedge clk);
    chk_cnt++;
    if ({if_a.out_valid, if_a.out_data, if_a.out_ch, if_a.out_last} !== {1'b1, 8'h05, 2'd0, 1'b1})
      $display("FAIL min_tie got=%h exp=%h", {if_a.out_valid, if_a.out_data, if_a.out_ch, if_a.out_last}, {1'b1, 8'h05, 2'd0, 1'b1});
    else pass_cnt++;
    if_a.pix_in = 24'h10E020; if_a.mode = 2'b10;
    @(negedge clk);
    chk_cnt++;
    if ({if_a.out_data, if_a.out_ch} !== {8'hE0, 2'd1})
      $display("FAIL max_mid got=%h exp=%h", {if_a.out_data, if_a.out_ch}, {8'hE0, 2'd1});
    else pass_cnt++;
    if_a.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_out_of_range();
    logic [7:0] exp_d;
    exp_d = 8'h00;
    @(negedge clk);
    if_a.pix_in = 24'h302010; if_a.mode = 2'b00; if_a.channel_select = 2'd3;
    if_a.in_valid = 1'b1; if_a.out_ready = 1'b1;
`ifdef CHANNEL_EXTRACT_INVERT_EN
    if_a.invert = 1'b1;
    exp_d = 8'hFF;
`endif
    @(negedge clk);
    if_a.in_valid = 1'b0;
`ifdef CHANNEL_EXTRACT_INVERT_EN
    if_a.invert = 1'b0;
`endif
    chk_cnt++;
    if ({if_a.out_valid, if_a.out_data, if_a.out_ch, if_a.out_last} !== {1'b1, exp_d, 2'd3, 1'b1})
      $display("FAIL sel_out_of_range got=%h exp=%h", {if_a.out_valid, if_a.out_data, if_a.out_ch, if_a.out_last}, {1'b1, exp_d, 2'd3, 1'b1});
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    if_a.pix_in = 24'hC3B2A1; if_a.mode = 2'b01; if_a.in_valid = 1'b1; if_a.out_ready = 1'b1;
    @(negedge clk);
    if_a.in_valid = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({if_a.out_valid, if_a.out_data} !== {1'b1, 8'hB2})
      $display("FAIL rstmid_beat1 got=%h exp=%h", {if_a.out_valid, if_a.out_data}, {1'b1, 8'hB2});
    else pass_cnt++;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if ({if_a.out_valid, if_a.in_ready, if_a.out_data, if_a.out_last} !== {1'b0, 1'b0, 8'h00, 1'b0})
      $display("FAIL rstmid_async got=%h exp=%h", {if_a.out_valid, if_a.in_ready, if_a.out_data, if_a.out_last}, {1'b0, 1'b0, 8'h00, 1'b0});
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_cnt++;
    if ({if_a.out_valid, if_a.in_ready} !== 2'b01)
      $display("FAIL rstmid_release got=%b exp=01", {if_a.out_valid, if_a.in_ready});
    else pass_cnt++;
    if_a.pix_in = 24'h302010; if_a.mode = 2'b00; if_a.channel_select = 2'd0; if_a.in_valid = 1'b1;
    @(negedge clk);
    if_a.in_valid = 1'b0;
    chk_cnt++;
    if ({if_a.out_valid, if_a.out_data, if_a.out_ch, if_a.out_last} !== {1'b1, 8'h10, 2'd0, 1'b1})
      $display("FAIL rstmid_next got=%h exp=%h", {if_a.out_valid, if_a.out_data, if_a.out_ch, if_a.out_last}, {1'b1, 8'h10, 2'd0, 1'b1});
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (if_a.out_valid !== 1'b0) $display("FAIL rstmid_no_leftover got=%b exp=0", if_a.out_valid);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic                 pend;
    logic [B_DW*B_NC-1:0] pix;
    logic [1:0]           mode, sel;
    logic                 inv;
    beat_t                got, e;
    int                   drain;
    pend = 1'b0; pix = '0; mode = '0; sel = '0; inv = 1'b0;
    exp_q.delete();
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      if (!pend && $urandom_range(0, 3) != 0) begin
        for (int k = 0; k < B_NC; k++)
          pix[k*B_DW +: B_DW] = ($urandom_range(0, 1) != 0) ? B_DW'($urandom_range(0, 3)) : B_DW'($urandom);
        mode = 2'($urandom_range(0, 3));
        sel  = 2'($urandom_range(0, 3));
`ifdef CHANNEL_EXTRACT_INVERT_EN
        inv  = 1'($urandom_range(0, 1));
        if_b.invert = inv;
`endif
        if_b.pix_in = pix; if_b.mode = mode; if_b.channel_select = sel;
        pend = 1'b1;
      end
      if_b.in_valid  = pend;
      if_b.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (if_b.out_valid && if_b.out_ready) begin
        got = {if_b.out_data, if_b.out_ch, if_b.out_last};
        chk_cnt++;
        if (exp_q.size() == 0) $display("FAIL rand_extra_beat got=%h exp=none", got);
        else begin
          e = exp_q.pop_front();
          if (got !== e) $display("FAIL rand_beat got=%h exp=%h", got, e);
          else pass_cnt++;
        end
      end
      if (pend && if_b.in_ready) begin
        model_push(pix, mode, sel, inv);
        pend = 1'b0;
      end
    end
    drain = 0;
    while ((exp_q.size() != 0 || if_b.out_valid) && drain < 64) begin
      @(negedge clk);
      if_b.in_valid = 1'b0;
      if_b.out_ready = 1'b1;
      #1;
      if (if_b.out_valid) begin
        got = {if_b.out_data, if_b.out_ch, if_b.out_last};
        chk_cnt++;
        if (exp_q.size() == 0) $display("FAIL rand_extra_beat got=%h exp=none", got);
        else begin
          e = exp_q.pop_front();
          if (got !== e) $display("FAIL rand_beat got=%h exp=%h", got, e);
          else pass_cnt++;
        end
      end
      drain++;
    end
    chk_cnt++;
    if (exp_q.size() != 0 || if_b.out_valid !== 1'b0)
      $display("FAIL rand_drain got=%0d beats left exp=0", exp_q.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_serialise();
    test_maxmin();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
